// File: rtl/td4_wide_cpu.sv
// td4_wide_cpu: single-cycle TD4-style CPU with parameterised data/address width
// and an optional HLT opcode.
module td4_wide_cpu #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 4,
  parameter bit HALT_EN = 1'b0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] a,
  input  logic [DATA_W+3:0] d,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              halt
);
  logic [ADDR_W-1:0] pc, pc_n;
  logic [DATA_W-1:0] ra, rb, im, ra_n, rb_n, out_n;
  logic [3:0] op;
  logic [DATA_W:0] sum;
  logic c, c_n, hlt;
  always_comb begin
    op    = d[DATA_W+3:DATA_W];
    im    = d[DATA_W-1:0];
    sum   = {1'b0, (op == 4'h5 ? rb : ra)} + {1'b0, im};
    hlt   = HALT_EN && op == 4'h8;
    c_n   = (op == 4'h0 || op == 4'h5) && sum[DATA_W];
    pc_n  = (op == 4'hf || (op == 4'he && !c)) ? im[ADDR_W-1:0] : pc + ADDR_W'(1);
    ra_n  = op == 4'h0 ? sum[DATA_W-1:0] :
            op == 4'h3 ? im :
            op == 4'h1 ? rb :
            op == 4'h2 ? in : ra;
    rb_n  = op == 4'h5 ? sum[DATA_W-1:0] :
            op == 4'h7 ? im :
            op == 4'h4 ? ra :
            op == 4'h6 ? in : rb;
    out_n = op == 4'h9 ? rb :
            op == 4'hb ? im : out;
  end
  assign a = pc;
  // HLT freezes everything except the halt flag itself, which only clr clears
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc   <= '0;
      ra   <= '0;
      rb   <= '0;
      c    <= 1'b0;
      out  <= '0;
      halt <= 1'b0;
    end else if (en && !halt) begin
      if (hlt) halt <= 1'b1;
      else begin
        pc  <= pc_n;
        ra  <= ra_n;
        rb  <= rb_n;
        c   <= c_n;
        out <= out_n;
      end
    end
  end
endmodule

// File: tb/tb_td4_wide_cpu.sv
// tb_td4_wide_cpu: three lockstep instances (default, halt-enabled, 8/6-bit wide)
// checked against a behavioural ISA model through an expected-state queue.
module tb_td4_wide_cpu;
  typedef struct {
    logic [7:0] pc, ra, rb, out;
    logic       c, halt;
  } st_t;

  logic clk = 1'b0, clr_n = 1'b0, en = 1'b1;
  logic [7:0] in_v = '0;
  logic [11:0] rom [3][64];
  logic [3:0] a0, a1, o0, o1;
  logic [5:0] a2;
  logic [7:0] o2;
  logic h0, h1, h2;
  logic [7:0] oa[3], oo[3], ora[3], orb[3];
  logic oc[3], oh[3];
  st_t cur[3];
  st_t q[3][$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  td4_wide_cpu u0 (.clk(clk), .clr(clr_n), .en(en), .a(a0), .d(rom[0][a0][7:0]),
                   .in(in_v[3:0]), .out(o0), .halt(h0));
  td4_wide_cpu #(.HALT_EN(1'b1)) u1 (.clk(clk), .clr(clr_n), .en(en), .a(a1),
                   .d(rom[1][a1][7:0]), .in(in_v[3:0]), .out(o1), .halt(h1));
  td4_wide_cpu #(.DATA_W(8), .ADDR_W(6)) u2 (.clk(clk), .clr(clr_n), .en(en), .a(a2),
                   .d(rom[2][a2]), .in(in_v), .out(o2), .halt(h2));

  assign oa[0] = {4'b0, a0};
  assign oa[1] = {4'b0, a1};
  assign oa[2] = {2'b0, a2};
  assign oo[0] = {4'b0, o0};
  assign oo[1] = {4'b0, o1};
  assign oo[2] = o2;
  assign oh[0] = h0;
  assign oh[1] = h1;
  assign oh[2] = h2;
  assign ora[0] = {4'b0, u0.ra};
  assign ora[1] = {4'b0, u1.ra};
  assign ora[2] = u2.ra;
  assign orb[0] = {4'b0, u0.rb};
  assign orb[1] = {4'b0, u1.rb};
  assign orb[2] = u2.rb;
  assign oc[0] = u0.c;
  assign oc[1] = u1.c;
  assign oc[2] = u2.c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic st_t mstep(st_t s, logic [11:0] w, logic [7:0] iv, logic ev, int k);
    int dw = (k == 2) ? 8 : 4;
    int aw = (k == 2) ? 6 : 4;
    int dm = (1 << dw) - 1;
    int am = (1 << aw) - 1;
    int op = (int'(w) >> dw) & 15;
    int im = int'(w) & dm;
    int t;
    st_t n = s;
    if (!ev || s.halt) return s;
    n.c  = 1'b0;
    n.pc = 8'((int'(s.pc) + 1) & am);
    case (op)
      0:  begin t = int'(s.ra) + im; n.ra = 8'(t & dm); n.c = t > dm; end
      5:  begin t = int'(s.rb) + im; n.rb = 8'(t & dm); n.c = t > dm; end
      3:  n.ra = 8'(im);
      7:  n.rb = 8'(im);
      1:  n.ra = s.rb;
      4:  n.rb = s.ra;
      2:  n.ra = iv & 8'(dm);
      6:  n.rb = iv & 8'(dm);
      9:  n.out = s.rb;
      11: n.out = 8'(im);
      15: n.pc = 8'(im & am);
      14: if (!s.c) n.pc = 8'(im & am);
      8:  if (k == 1) begin n = s; n.halt = 1'b1; end
      default: ;
    endcase
    return n;
  endfunction

  task automatic step();
    st_t e;
    for (int k = 0; k < 3; k++) begin
      e = mstep(cur[k], rom[k][cur[k].pc[5:0]], in_v, en, k);
      q[k].push_back(e);
      cur[k] = e;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = q[k].pop_front();
      chk($sformatf("i%0d_a", k), {24'b0, oa[k]}, {24'b0, e.pc});
      chk($sformatf("i%0d_out", k), {24'b0, oo[k]}, {24'b0, e.out});
      chk($sformatf("i%0d_halt", k), {31'b0, oh[k]}, {31'b0, e.halt});
      chk($sformatf("i%0d_ra", k), {24'b0, ora[k]}, {24'b0, e.ra});
      chk($sformatf("i%0d_rb", k), {24'b0, orb[k]}, {24'b0, e.rb});
      chk($sformatf("i%0d_c", k), {31'b0, oc[k]}, {31'b0, e.c});
    end
  endtask

  task automatic do_reset();
    #2 clr_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      cur[k] = '{default: '0};
      chk($sformatf("rst_i%0d_a", k), {24'b0, oa[k]}, 32'h0);
      chk($sformatf("rst_i%0d_out", k), {24'b0, oo[k]}, 32'h0);
      chk($sformatf("rst_i%0d_halt", k), {31'b0, oh[k]}, 32'h0);
      chk($sformatf("rst_i%0d_ra", k), {24'b0, ora[k]}, 32'h0);
    end
    #1 clr_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      cur[k] = '{default: '0};
      for (int i = 0; i < 64; i++) rom[k][i] = (k == 2) ? 12'($urandom) : 12'($urandom & 8'hff);
    end
    rom[0][0] = 12'h20; rom[0][1] = 12'h40; rom[0][2] = 12'h90; rom[0][3] = 12'h33;
    rom[0][4] = 12'h0e; rom[0][5] = 12'he0; rom[0][6] = 12'h80;
    rom[1][0] = 12'hb5; rom[1][1] = 12'h80;
    rom[2][0] = 12'h3f0; rom[2][1] = 12'h020; rom[2][2] = 12'hfff; rom[2][63] = 12'hc00;
    in_v = 8'h0d;
    #3;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("init_i%0d_a", k), {24'b0, oa[k]}, 32'h0);
      chk($sformatf("init_i%0d_out", k), {24'b0, oo[k]}, 32'h0);
      chk($sformatf("init_i%0d_halt", k), {31'b0, oh[k]}, 32'h0);
    end
    clr_n = 1'b1;
    step();
    chk("halt_out5", {28'b0, o1}, 32'h5);
    step();
    chk("halt_set", {31'b0, h1}, 32'h1);
    chk("halt_a1", {28'b0, a1}, 32'h1);
    chk("wide_add_ra", {24'b0, u2.ra}, 32'h10);
    chk("wide_add_c", {31'b0, u2.c}, 32'h1);
    step();
    chk("io_out", {28'b0, o0}, 32'hd);
    chk("io_a", {28'b0, a0}, 32'h3);
    chk("wide_jmp_a", {26'b0, a2}, 32'h3f);
    step();
    chk("wide_wrap_a", {26'b0, a2}, 32'h0);
    step();
    chk("cy_ra", {28'b0, u0.ra}, 32'h1);
    chk("cy_c", {31'b0, u0.c}, 32'h1);
    step();
    chk("jnc_a", {28'b0, a0}, 32'h6);
    chk("jnc_c", {31'b0, u0.c}, 32'h0);
    step();
    chk("nop8_a", {28'b0, a0}, 32'h7);
    en = 1'b0;
    repeat (4) step();
    chk("en_a", {28'b0, a0}, 32'h7);
    chk("en_out", {28'b0, o0}, 32'hd);
    en = 1'b1;
    repeat (3) step();
    chk("halt_hold_a", {28'b0, a1}, 32'h1);
    chk("halt_hold_out", {28'b0, o1}, 32'h5);
    for (int i = 0; i < 150; i++) begin
      en = $urandom_range(0, 7) != 0;
      in_v = 8'($urandom);
      step();
    end
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) rom[k][i] = 12'($urandom & 8'hff);
    rom[0][0] = 12'h20;
    en = 1'b1;
    in_v = 8'h0a;
    step();
    chk("resume_a", {28'b0, a0}, 32'h1);
    chk("resume_ra", {28'b0, u0.ra}, 32'ha);
    for (int i = 0; i < 150; i++) begin
      en = $urandom_range(0, 7) != 0;
      in_v = 8'($urandom);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
